// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared timing constants and helpers for the VGA raster generator
//
// Purpose: default 640x480@60 timing, counter widths and line/frame total helpers.
// Ports: none (package).
package vga_timing_pkg;

   localparam int CNT_W   = 10;
   localparam int FRAME_W = 8;

   localparam int DEF_H_VIEW  = 640;
   localparam int DEF_H_FRONT = 16;
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BACK  = 48;
   localparam int DEF_V_VIEW  = 480;
   localparam int DEF_V_FRONT = 10;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BACK  = 33;

   function automatic int h_total(int view, int front, int sync, int back);
      return view + front + sync + back;
   endfunction

   function automatic int v_total(int view, int front, int sync, int back);
      return view + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster position and sync/blank bundle toward the colour stage
//
// Purpose: groups every timing output of vga_sync_gen.
// Signals: hpos, vpos, hsync, vsync, hblank, vblank, visible, line_start,
//          frame_start, frame.
// Modports: master (generator drives), slave (colour logic reads).
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic [CNT_W-1:0]   hpos;
   logic [CNT_W-1:0]   vpos;
   logic               hsync;
   logic               vsync;
   logic               hblank;
   logic               vblank;
   logic               visible;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame;

   modport master (
      output hpos, vpos, hsync, vsync, hblank, vblank,
             visible, line_start, frame_start, frame
   );

   modport slave (
      input  hpos, vpos, hsync, vsync, hblank, vblank,
             visible, line_start, frame_start, frame
   );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with blank/sync flags
//
// Purpose: counts VIEW+FRONT+SYNC+BACK positions, registering blank and sync from
//          the next-state position so flags line up with pos_o.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   tick_i          advance by one position
//   wrap_en_i       allow return to 0 after the last position (else hold there)
//   pos_o           current position
//   pos_next_o      position after this edge (for registering derived flags)
//   blank_o         pos_o >= VIEW
//   sync_o          sync window, active level SYNC_POL
//   wrap_o          this edge wraps the axis back to 0
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VIEW     = DEF_H_VIEW,
   parameter int FRONT    = DEF_H_FRONT,
   parameter int SYNC     = DEF_H_SYNC,
   parameter int BACK     = DEF_H_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             tick_i,
   input  logic             wrap_en_i,
   output logic [CNT_W-1:0] pos_o,
   output logic [CNT_W-1:0] pos_next_o,
   output logic             blank_o,
   output logic             sync_o,
   output logic             wrap_o
);

   localparam int               TOTAL   = VIEW + FRONT + SYNC + BACK;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] VIEW_C  = CNT_W'(VIEW);
   localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIEW + FRONT);
   localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIEW + FRONT + SYNC - 1);

   logic [CNT_W-1:0] pos_q, pos_d;
   logic             blank_q, blank_d;
   logic             sync_q, sync_d;
   logic             at_last;

   always_comb begin
      at_last = (pos_q == LAST);
      pos_d   = pos_q;
      if (tick_i) begin
         if (at_last) begin
            pos_d = wrap_en_i ? '0 : pos_q;
         end else begin
            pos_d = pos_q + CNT_W'(1);
         end
      end
      // Flags follow the next position so they change on the same edge as pos.
      blank_d = (pos_d >= VIEW_C);
      sync_d  = ((pos_d >= SYNC_LO) && (pos_d <= SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pos_q   <= '0;
         blank_q <= 1'b0;
         sync_q  <= ~SYNC_POL;
      end else begin
         pos_q   <= pos_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign pos_o      = pos_q;
   assign pos_next_o = pos_d;
   assign blank_o    = blank_q;
   assign sync_o     = sync_q;
   assign wrap_o     = tick_i && at_last && wrap_en_i;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator (hsync/vsync/blank, pixel coordinates)
//
// Purpose: horizontal and vertical axis counters plus registered visible,
//          line_start, frame_start and an optional frame counter.
// Build option: VGA_SYNC_FRAME_COUNTER_EN builds the 8-bit frame counter;
//               without it frame is constant 0.
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   ena    advance enable; all outputs hold while low
//   vga    vga_sync_gen_if.master: hpos, vpos, hsync, vsync, hblank, vblank,
//          visible, line_start, frame_start, frame
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VIEW   = DEF_H_VIEW,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_VIEW   = DEF_V_VIEW,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = h_total(H_VIEW, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_VIEW, V_FRONT, V_SYNC, V_BACK);

   if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_timing_check
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the position counter range");
   end

   logic             h_wrap, v_wrap;
   logic [CNT_W-1:0] h_next, v_next;

   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic visible_q, visible_d;

   vga_axis_counter #(
      .VIEW(H_VIEW), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(SYNC_POL)
   ) u_h_axis (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .tick_i     (ena),
      .wrap_en_i  (1'b1),
      .pos_o      (vga.hpos),
      .pos_next_o (h_next),
      .blank_o    (vga.hblank),
      .sync_o     (vga.hsync),
      .wrap_o     (h_wrap)
   );

   // h_wrap already carries ena, so the vertical axis steps once per line.
   vga_axis_counter #(
      .VIEW(V_VIEW), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(SYNC_POL)
   ) u_v_axis (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .tick_i     (h_wrap),
      .wrap_en_i  (1'b1),
      .pos_o      (vga.vpos),
      .pos_next_o (v_next),
      .blank_o    (vga.vblank),
      .sync_o     (vga.vsync),
      .wrap_o     (v_wrap)
   );

   always_comb begin
      line_start_d  = (h_next == '0);
      frame_start_d = (h_next == '0) && (v_next == '0);
      visible_d     = (h_next < CNT_W'(H_VIEW)) && (v_next < CNT_W'(V_VIEW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
         visible_q     <= 1'b1;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         visible_q     <= visible_d;
      end
   end

   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.visible     = visible_q;

`ifdef VGA_SYNC_FRAME_COUNTER_EN
   logic [FRAME_W-1:0] frame_q, frame_d;

   always_comb begin
      frame_d = v_wrap ? (frame_q + FRAME_W'(1)) : frame_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else begin
         frame_q <= frame_d;
      end
   end

   assign vga.frame = frame_q;
`else
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;
   assign vga.frame     = '0;
`endif

endmodule
